// File: rtl/vm3_arb_pkg.sv
// vm3_arb_pkg: shared types for the vm3 Q-bus arbiter.
// FSM states, requester indices, OWNER "none" code, winner search helpers.
package vm3_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [1:0] REQ_MCPU   = 2'd0;
  localparam logic [1:0] REQ_SCPU   = 2'd1;
  localparam logic [1:0] REQ_EXT    = 2'd2;
  localparam logic [1:0] OWNER_NONE = 2'b11;

  // Successor of a requester index, mod 3.
  function automatic logic [1:0] nextIdx(
    input logic [1:0] w
  );
    logic [1:0] n;
    unique case (1'b1)
      (w == REQ_MCPU): n = REQ_SCPU;
      (w == REQ_SCPU): n = REQ_EXT;
      default:         n = REQ_MCPU;
    endcase
    return n;
  endfunction

  // First active request found walking from the start index,
  // OWNER_NONE when nobody asks. Fixed mode starts at index 0.
  function automatic logic [1:0] pickWinner(
    input logic [2:0] req,
    input logic [1:0] ptr,
    input logic       rr
  );
    logic [1:0] idx;
    logic [1:0] res;
    res = OWNER_NONE;
    idx = rr ? ptr : REQ_MCPU;
    for (int k = 0; k < 3; k++) begin
      if (res == OWNER_NONE && req[idx])
        res = idx;
      idx = nextIdx(idx);
    end
    return res;
  endfunction

endpackage

// File: rtl/vm3_arb_sync.sv
// vm3_arb_sync: W-bit, STAGES-deep input synchronizer, resets to all ones.
// Ports: clk, rst_n (async low), d (async in), q (synchronized out).
module vm3_arb_sync #(
  parameter int W      = 1,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] ff [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++)
        ff[i] <= '1;
    end else begin
      ff[0] <= d;
      for (int i = 1; i < STAGES; i++)
        ff[i] <= ff[i-1];
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/vm3_arb.sv
// vm3_arb: Q-bus mastership arbiter, DMR/DMG/SACK/BSY handshake, 3 requesters.
// Ports: CLK, nDCLO (async reset), nDMR/nSACK/nBSY/nINIT in; nDMG, OWNER, TMO out.
module vm3_arb
  import vm3_arb_pkg::*;
#(
  parameter bit RR          = 1'b1,
  parameter int TIMEOUT     = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       nDCLO,
  input  logic [2:0] nDMR,
  input  logic [2:0] nSACK,
  input  logic       nBSY,
  input  logic       nINIT,
  output logic [2:0] nDMG,
  output logic [1:0] OWNER,
  output logic       TMO
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [2:0]    dmrS;
  logic [2:0]    sackS;
  logic          bsyS;
  logic          initS;

  state_t        state;
  state_t        stateNext;
  logic [1:0]    win;
  logic [1:0]    winNext;
  logic [1:0]    ptr;
  logic [1:0]    ptrNext;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cntNext;
  logic [2:0]    dmgNext;
  logic [1:0]    ownerNext;
  logic          tmoNext;

  logic [1:0]    pick;
  logic          start;
  logic          sackHit;
  logic          dropped;
  logic          expired;
  logic          released;

  vm3_arb_sync #(.W(3), .STAGES(SYNC_STAGES)) uSyncDmr (
    .clk   (CLK),
    .rst_n (nDCLO),
    .d     (nDMR),
    .q     (dmrS)
  );

  vm3_arb_sync #(.W(3), .STAGES(SYNC_STAGES)) uSyncSack (
    .clk   (CLK),
    .rst_n (nDCLO),
    .d     (nSACK),
    .q     (sackS)
  );

  vm3_arb_sync #(.W(1), .STAGES(SYNC_STAGES)) uSyncBsy (
    .clk   (CLK),
    .rst_n (nDCLO),
    .d     (nBSY),
    .q     (bsyS)
  );

  vm3_arb_sync #(.W(1), .STAGES(SYNC_STAGES)) uSyncInit (
    .clk   (CLK),
    .rst_n (nDCLO),
    .d     (nINIT),
    .q     (initS)
  );

  assign pick     = pickWinner(~dmrS, ptr, RR);
  assign start    = (pick != OWNER_NONE) && bsyS;
  assign sackHit  = !sackS[win];
  assign dropped  = dmrS[win];
  // Counter holds cycles already spent low; this edge is the last one.
  assign expired  = (cnt == CNT_LAST);
  assign released = sackS[win] && bsyS;

  always_ff @(posedge CLK or negedge nDCLO) begin
    if (!nDCLO) begin
      state <= IDLE;
      win   <= REQ_MCPU;
      ptr   <= REQ_MCPU;
      cnt   <= '0;
      nDMG  <= 3'b111;
      OWNER <= OWNER_NONE;
      TMO   <= 1'b0;
    end else begin
      state <= stateNext;
      win   <= winNext;
      ptr   <= ptrNext;
      cnt   <= cntNext;
      nDMG  <= dmgNext;
      OWNER <= ownerNext;
      TMO   <= tmoNext;
    end
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: begin
        if (start)
          stateNext = GRANT;
      end
      GRANT: begin
        // SACK outranks both withdrawal and timeout.
        if (sackHit)
          stateNext = HOLD;
        else if (dropped || expired)
          stateNext = IDLE;
      end
      HOLD: begin
        if (released)
          stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
    if (!initS)
      stateNext = IDLE;
  end

  // Next values for the registered outputs and bookkeeping.
  always_comb begin
    winNext   = win;
    ptrNext   = ptr;
    cntNext   = cnt;
    dmgNext   = nDMG;
    ownerNext = OWNER;
    tmoNext   = 1'b0;
    if (!initS) begin
      dmgNext   = 3'b111;
      ownerNext = OWNER_NONE;
      ptrNext   = REQ_MCPU;
      cntNext   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            winNext   = pick;
            ownerNext = pick;
            dmgNext   = ~(3'b001 << pick);
            cntNext   = '0;
          end
        end
        GRANT: begin
          cntNext = cnt + CW'(1);
          if (sackHit) begin
            dmgNext = 3'b111;
            ptrNext = nextIdx(win);
          end else if (dropped) begin
            dmgNext   = 3'b111;
            ownerNext = OWNER_NONE;
          end else if (expired) begin
            dmgNext   = 3'b111;
            ownerNext = OWNER_NONE;
            tmoNext   = 1'b1;
            ptrNext   = nextIdx(win);
          end
        end
        HOLD: begin
          if (released)
            ownerNext = OWNER_NONE;
        end
        default: begin
          dmgNext   = 3'b111;
          ownerNext = OWNER_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vm3_arb.sv
// tb_vm3_arb: directed scenarios plus randomized run against a reference model.
// Two arbiters share inputs: round-robin (TMO 64, 2 stages) and fixed (TMO 5, 3 stages).
module tb_vm3_arb;

  localparam int TO_RR = 64;
  localparam int TO_FX = 5;
  localparam int SS_RR = 2;
  localparam int SS_FX = 3;

  logic       clk = 1'b0;
  logic       nDCLO = 1'b0;
  logic [2:0] nDMR = 3'b111;
  logic [2:0] nSACK = 3'b111;
  logic       nBSY = 1'b1;
  logic       nINIT = 1'b1;

  logic [2:0] dmgRr;
  logic [1:0] ownRr;
  logic       tmoRr;
  logic [2:0] dmgFx;
  logic [1:0] ownFx;
  logic       tmoFx;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  vm3_arb #(.RR(1'b1), .TIMEOUT(TO_RR), .SYNC_STAGES(SS_RR)) uRr (
    .CLK   (clk),
    .nDCLO (nDCLO),
    .nDMR  (nDMR),
    .nSACK (nSACK),
    .nBSY  (nBSY),
    .nINIT (nINIT),
    .nDMG  (dmgRr),
    .OWNER (ownRr),
    .TMO   (tmoRr)
  );

  vm3_arb #(.RR(1'b0), .TIMEOUT(TO_FX), .SYNC_STAGES(SS_FX)) uFx (
    .CLK   (clk),
    .nDCLO (nDCLO),
    .nDMR  (nDMR),
    .nSACK (nSACK),
    .nBSY  (nBSY),
    .nINIT (nINIT),
    .nDMG  (dmgFx),
    .OWNER (ownFx),
    .TMO   (tmoFx)
  );

  // Reference model: owner (-1 none), whether the grant line is still
  // asserted, rotation start, cycles the grant has been low, timeout flag.
  // Synchronizers are modelled as an input history; an instance with
  // S stages acts on the inputs sampled S edges earlier.
  int         mOwner [2] = '{-1, -1};
  bit         mGrant [2] = '{0, 0};
  int         mPtr   [2] = '{0, 0};
  int         mWait  [2] = '{0, 0};
  bit         mTmo   [2] = '{0, 0};
  logic [7:0] hist   [4] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};

  task automatic modelStep(input int m, input bit rr, input int lim,
                           input logic [7:0] s);
    logic [2:0] dmr;
    logic [2:0] sack;
    logic       bsy;
    logic       init;
    int         w;
    int         idx;
    dmr  = s[7:5];
    sack = s[4:2];
    bsy  = s[1];
    init = s[0];
    mTmo[m] = 1'b0;
    w = mOwner[m];
    if (!init) begin
      mOwner[m] = -1;
      mGrant[m] = 1'b0;
      mPtr[m]   = 0;
    end else if (w < 0) begin
      if (bsy) begin
        for (int k = 0; k < 3; k++) begin
          idx = rr ? (mPtr[m] + k) % 3 : k;
          if (mOwner[m] < 0 && !dmr[idx]) begin
            mOwner[m] = idx;
            mGrant[m] = 1'b1;
            mWait[m]  = 0;
          end
        end
      end
    end else if (mGrant[m]) begin
      mWait[m]++;
      if (!sack[w]) begin
        mGrant[m] = 1'b0;
        mPtr[m]   = (w + 1) % 3;
      end else if (dmr[w]) begin
        mGrant[m] = 1'b0;
        mOwner[m] = -1;
      end else if (mWait[m] == lim) begin
        mGrant[m] = 1'b0;
        mOwner[m] = -1;
        mTmo[m]   = 1'b1;
        mPtr[m]   = (w + 1) % 3;
      end
    end else if (sack[w] && bsy) begin
      mOwner[m] = -1;
    end
  endtask

  always @(posedge clk or negedge nDCLO) begin
    if (!nDCLO) begin
      for (int m = 0; m < 2; m++) begin
        mOwner[m] = -1;
        mGrant[m] = 1'b0;
        mPtr[m]   = 0;
        mWait[m]  = 0;
        mTmo[m]   = 1'b0;
      end
      for (int i = 0; i < 4; i++)
        hist[i] = 8'hFF;
    end else begin
      for (int i = 3; i > 0; i--)
        hist[i] = hist[i-1];
      hist[0] = {nDMR, nSACK, nBSY, nINIT};
      modelStep(0, 1'b1, TO_RR, hist[SS_RR]);
      modelStep(1, 1'b0, TO_FX, hist[SS_FX]);
    end
  end

  function automatic logic [2:0] expDmg(input int m);
    return mGrant[m] ? ~(3'b001 << mOwner[m]) : 3'b111;
  endfunction

  function automatic logic [1:0] expOwn(input int m);
    return (mOwner[m] < 0) ? 2'b11 : 2'(mOwner[m]);
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic [2:0] d, input logic [2:0] s,
                       input logic b, input logic i);
    nDMR  = d;
    nSACK = s;
    nBSY  = b;
    nINIT = i;
  endtask

  // Withdraw everything long enough for any pending grant to expire.
  task automatic settle();
    drive(3'b111, 3'b111, 1'b1, 1'b1);
    cyc(80);
  endtask

  task automatic test_reset();
    nDCLO = 1'b0;
    drive(3'b111, 3'b111, 1'b1, 1'b1);
    cyc(3);
    tests++;
    if (dmgRr !== 3'b111 || dmgFx !== 3'b111) begin
      fails++;
      $display("FAIL reset nDMG: got %b/%b want 111", dmgRr, dmgFx);
    end
    tests++;
    if (ownRr !== 2'b11 || ownFx !== 2'b11) begin
      fails++;
      $display("FAIL reset OWNER: got %0d/%0d want 3", ownRr, ownFx);
    end
    tests++;
    if (tmoRr !== 1'b0 || tmoFx !== 1'b0) begin
      fails++;
      $display("FAIL reset TMO: got %b/%b want 0", tmoRr, tmoFx);
    end
    nDCLO = 1'b1;
    cyc(3);
    tests++;
    if (dmgRr !== 3'b111 || ownRr !== 2'b11) begin
      fails++;
      $display("FAIL post-reset idle: nDMG %b OWNER %0d want 111/3", dmgRr, ownRr);
    end
  endtask

  // All three request continuously; a responder acknowledges every grant
  // of the selected arbiter and the order of winners is recorded.
  task automatic test_round_robin(input bit fx, input logic [7:0] expSeq);
    int         got [$];
    int         hold;
    bit         busy;
    int         idx;
    logic [2:0] g;
    logic [1:0] want;
    logic [7:0] seq;
    hold = 0;
    busy = 1'b0;
    seq  = expSeq;
    drive(3'b000, 3'b111, 1'b1, 1'b1);
    for (int c = 0; c < 400 && got.size() < 4; c++) begin
      @(negedge clk);
      g = fx ? dmgFx : dmgRr;
      if (!busy) begin
        if (g != 3'b111) begin
          idx = (g == 3'b110) ? 0 : (g == 3'b101) ? 1 : (g == 3'b011) ? 2 : 3;
          got.push_back(idx);
          nSACK = g;
          nBSY  = 1'b0;
          busy  = 1'b1;
          hold  = 0;
        end
      end else begin
        hold++;
        if (hold == 8) begin
          nSACK = 3'b111;
          nBSY  = 1'b1;
          busy  = 1'b0;
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      want = seq[2*i +: 2];
      tests++;
      if (i >= got.size()) begin
        fails++;
        $display("FAIL rr%0d grant %0d: got none want %0d", fx, i, want);
      end else if (got[i] != int'(want)) begin
        fails++;
        $display("FAIL rr%0d grant %0d: got %0d want %0d", fx, i, got[i], want);
      end
    end
    settle();
  endtask

  task automatic test_single();
    drive(3'b110, 3'b111, 1'b1, 1'b1);
    cyc(2);
    tests++;
    if (dmgRr !== 3'b111) begin
      fails++;
      $display("FAIL single early grant: got %b want 111", dmgRr);
    end
    cyc(1);
    tests++;
    if (dmgRr !== 3'b110 || ownRr !== 2'd0) begin
      fails++;
      $display("FAIL single grant: nDMG %b OWNER %0d want 110/0", dmgRr, ownRr);
    end
    cyc(5);
    drive(3'b111, 3'b110, 1'b0, 1'b1);
    cyc(2);
    tests++;
    if (dmgRr !== 3'b110) begin
      fails++;
      $display("FAIL single early release: got %b want 110", dmgRr);
    end
    cyc(1);
    tests++;
    if (dmgRr !== 3'b111 || ownRr !== 2'd0 || tmoRr !== 1'b0) begin
      fails++;
      $display("FAIL single hold: nDMG %b OWNER %0d TMO %b want 111/0/0",
               dmgRr, ownRr, tmoRr);
    end
    cyc(10);
    drive(3'b111, 3'b111, 1'b1, 1'b1);
    cyc(2);
    tests++;
    if (ownRr !== 2'd0) begin
      fails++;
      $display("FAIL single early idle: OWNER %0d want 0", ownRr);
    end
    cyc(1);
    tests++;
    if (ownRr !== 2'b11) begin
      fails++;
      $display("FAIL single idle: OWNER %0d want 3", ownRr);
    end
    drive(3'b100, 3'b111, 1'b1, 1'b1);
    cyc(3);
    tests++;
    if (dmgRr !== 3'b101 || ownRr !== 2'd1) begin
      fails++;
      $display("FAIL single pointer: nDMG %b OWNER %0d want 101/1", dmgRr, ownRr);
    end
    settle();
  endtask

  task automatic test_withdraw();
    drive(3'b011, 3'b111, 1'b1, 1'b1);
    cyc(3);
    tests++;
    if (dmgRr !== 3'b011) begin
      fails++;
      $display("FAIL withdraw grant: got %b want 011", dmgRr);
    end
    drive(3'b111, 3'b111, 1'b1, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      cyc(1);
      tests++;
      if (tmoRr !== 1'b0) begin
        fails++;
        $display("FAIL withdraw TMO cycle %0d: got %b want 0", k, tmoRr);
      end
      if (k == 2) begin
        tests++;
        if (dmgRr !== 3'b011) begin
          fails++;
          $display("FAIL withdraw early: got %b want 011", dmgRr);
        end
      end
      if (k == 3) begin
        tests++;
        if (dmgRr !== 3'b111 || ownRr !== 2'b11) begin
          fails++;
          $display("FAIL withdraw idle: nDMG %b OWNER %0d want 111/3", dmgRr, ownRr);
        end
      end
    end
    drive(3'b000, 3'b111, 1'b1, 1'b1);
    cyc(3);
    tests++;
    if (dmgRr !== 3'b101 || ownRr !== 2'd1) begin
      fails++;
      $display("FAIL withdraw pointer: nDMG %b OWNER %0d want 101/1", dmgRr, ownRr);
    end
    settle();
  endtask

  task automatic test_timeout();
    drive(3'b101, 3'b111, 1'b1, 1'b1);
    cyc(3);
    tests++;
    if (dmgRr !== 3'b101) begin
      fails++;
      $display("FAIL timeout grant: got %b want 101", dmgRr);
    end
    drive(3'b001, 3'b111, 1'b1, 1'b1);
    for (int k = 1; k <= 65; k++) begin
      cyc(1);
      if (k == 63) begin
        tests++;
        if (dmgRr !== 3'b101 || tmoRr !== 1'b0) begin
          fails++;
          $display("FAIL timeout last low: nDMG %b TMO %b want 101/0", dmgRr, tmoRr);
        end
      end
      if (k == 64) begin
        tests++;
        if (dmgRr !== 3'b111 || tmoRr !== 1'b1 || ownRr !== 2'b11) begin
          fails++;
          $display("FAIL timeout pulse: nDMG %b TMO %b OWNER %0d want 111/1/3",
                   dmgRr, tmoRr, ownRr);
        end
      end
      if (k == 65) begin
        tests++;
        if (dmgRr !== 3'b011 || tmoRr !== 1'b0 || ownRr !== 2'd2) begin
          fails++;
          $display("FAIL timeout next: nDMG %b TMO %b OWNER %0d want 011/0/2",
                   dmgRr, tmoRr, ownRr);
        end
      end
    end
    settle();
  endtask

  // SACK reaches the FSM on exactly the edge the grant would expire.
  task automatic test_sack_timeout();
    drive(3'b110, 3'b111, 1'b1, 1'b1);
    cyc(3);
    tests++;
    if (dmgRr !== 3'b110) begin
      fails++;
      $display("FAIL race grant: got %b want 110", dmgRr);
    end
    cyc(61);
    drive(3'b110, 3'b110, 1'b0, 1'b1);
    cyc(2);
    tests++;
    if (dmgRr !== 3'b110) begin
      fails++;
      $display("FAIL race last low: got %b want 110", dmgRr);
    end
    cyc(1);
    tests++;
    if (dmgRr !== 3'b111 || ownRr !== 2'd0 || tmoRr !== 1'b0) begin
      fails++;
      $display("FAIL race hold: nDMG %b OWNER %0d TMO %b want 111/0/0",
               dmgRr, ownRr, tmoRr);
    end
    cyc(1);
    tests++;
    if (tmoRr !== 1'b0 || ownRr !== 2'd0) begin
      fails++;
      $display("FAIL race after: TMO %b OWNER %0d want 0/0", tmoRr, ownRr);
    end
    drive(3'b111, 3'b111, 1'b1, 1'b1);
    cyc(3);
    tests++;
    if (ownRr !== 2'b11) begin
      fails++;
      $display("FAIL race release: OWNER %0d want 3", ownRr);
    end
    settle();
  endtask

  task automatic test_busy();
    drive(3'b011, 3'b111, 1'b0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      cyc(1);
      tests++;
      if (dmgRr !== 3'b111) begin
        fails++;
        $display("FAIL busy blocked cycle %0d: got %b want 111", k, dmgRr);
      end
    end
    drive(3'b011, 3'b111, 1'b1, 1'b1);
    cyc(2);
    tests++;
    if (dmgRr !== 3'b111) begin
      fails++;
      $display("FAIL busy early: got %b want 111", dmgRr);
    end
    cyc(1);
    tests++;
    if (dmgRr !== 3'b011 || ownRr !== 2'd2) begin
      fails++;
      $display("FAIL busy grant: nDMG %b OWNER %0d want 011/2", dmgRr, ownRr);
    end
    settle();
  endtask

  task automatic test_init(input int w);
    logic [2:0] sel;
    sel = ~(3'b001 << w);
    drive(sel, 3'b111, 1'b1, 1'b1);
    cyc(3);
    drive(sel, sel, 1'b0, 1'b1);
    cyc(3);
    tests++;
    if (dmgRr !== 3'b111 || ownRr !== 2'(w)) begin
      fails++;
      $display("FAIL init%0d hold: nDMG %b OWNER %0d want 111/%0d", w, dmgRr, ownRr, w);
    end
    nINIT = 1'b0;
    cyc(1);
    nINIT = 1'b1;
    cyc(1);
    tests++;
    if (ownRr !== 2'(w)) begin
      fails++;
      $display("FAIL init%0d early: OWNER %0d want %0d", w, ownRr, w);
    end
    cyc(1);
    tests++;
    if (ownRr !== 2'b11 || dmgRr !== 3'b111 || tmoRr !== 1'b0) begin
      fails++;
      $display("FAIL init%0d abort: OWNER %0d nDMG %b TMO %b want 3/111/0",
               w, ownRr, dmgRr, tmoRr);
    end
    drive(3'b000, 3'b111, 1'b1, 1'b1);
    cyc(3);
    tests++;
    if (dmgRr !== 3'b110 || ownRr !== 2'd0) begin
      fails++;
      $display("FAIL init%0d pointer: nDMG %b OWNER %0d want 110/0", w, dmgRr, ownRr);
    end
    settle();
  endtask

  task automatic test_random(input int n);
    logic [2:0] gd;
    logic [1:0] go;
    logic       gt;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        gd = m ? dmgFx : dmgRr;
        go = m ? ownFx : ownRr;
        gt = m ? tmoFx : tmoRr;
        tests++;
        if (gd !== expDmg(m)) begin
          fails++;
          $display("FAIL rand%0d cyc %0d nDMG: got %b want %b", m, c, gd, expDmg(m));
        end
        tests++;
        if (go !== expOwn(m)) begin
          fails++;
          $display("FAIL rand%0d cyc %0d OWNER: got %0d want %0d", m, c, go, expOwn(m));
        end
        tests++;
        if (gt !== mTmo[m]) begin
          fails++;
          $display("FAIL rand%0d cyc %0d TMO: got %b want %b", m, c, gt, mTmo[m]);
        end
      end
      for (int b = 0; b < 3; b++) begin
        if ($urandom_range(7) == 0)
          nDMR[b] = ~nDMR[b];
        if ($urandom_range(5) == 0)
          nSACK[b] = ~nSACK[b];
      end
      nBSY  = ($urandom_range(3) != 0);
      nINIT = ($urandom_range(99) != 0);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin(1'b0, {2'd0, 2'd2, 2'd1, 2'd0});
    test_round_robin(1'b1, 8'h00);
    test_single();
    test_withdraw();
    test_timeout();
    test_sack_timeout();
    test_busy();
    test_init(2);
    test_init(0);
    test_random(3000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
